fpu_sub_normround: RTL and testbench

- Multi-cycle normalize-and-round stage directly downstream of the double-precision subtraction datapath.
- Consumes the raw difference: sign, biased exponent and an unnormalized 57-bit mantissa with guard/round/sticky.
- Produces an IEEE-754 binary64 result `c` using round-to-nearest-even, with exception flags.
- Uses a valid/ready handshake on both sides so the subtractor and downstream writeback can stall independently.

---
 rtl/fpu_sub_normround.sv | 107 ++++++++++
 tb/tb_fpu_sub_normround.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sub_normround.sv
// fpu_sub_normround: normalize and round-to-nearest-even a raw binary64 difference.
module fpu_sub_normround #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int MANT_W = 57
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [MANT_W-1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         c,
    output logic                overflow,
    output logic                underflow,
    output logic                inexact
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, ROUND = 2'd2, DONE = 2'd3;

    logic [1:0]        state;
    logic              sign;
    logic [EXP_W:0]    exp;
    logic [MANT_W-1:0] mant;
    logic [5:0]        cnt;

    // SHIFT is only entered when a left shift is actually due, so k shifts cost k cycles
    function automatic logic needs(input logic [MANT_W-1:0] m, input logic [EXP_W:0] e, input logic [5:0] n);
        return !m[55] && e > (EXP_W+1)'(1) && n < 6'd54;
    endfunction

    logic [MANT_W-1:0] cap_mant, sh_mant;
    logic [EXP_W:0]    cap_exp, sh_exp, rexp;
    logic [5:0]        sh_cnt;
    logic              g, r, s, up, carry, hid, rinx, ovf;
    logic [53:0]       sum;
    logic [FRAC_W-1:0] rfrac;
    logic [63:0]       c_next;

    assign cap_mant = in_mant[56] ? {1'b0, in_mant[56:2], in_mant[1] | in_mant[0]} : in_mant;
    assign cap_exp  = (in_exp == '0 ? (EXP_W+1)'(1) : {1'b0, in_exp}) + {{EXP_W{1'b0}}, in_mant[56]};
    assign sh_mant  = mant << 1;
    assign sh_exp   = exp - (EXP_W+1)'(1);
    assign sh_cnt   = cnt + 6'd1;

    assign {g, r, s} = mant[2:0];
    assign up     = g & (r | s | mant[3]);
    assign sum    = mant[56:3] + {53'b0, up};
    assign carry  = sum[53];
    assign hid    = carry | sum[52];
    assign rexp   = exp + {{EXP_W{1'b0}}, carry};
    assign rfrac  = carry ? sum[52:1] : sum[51:0];
    assign rinx   = g | r | s;
    assign ovf    = rexp >= (EXP_W+1)'(2047);
    assign c_next = ovf ? {sign, 11'h7FF, 52'b0} : {sign, hid ? rexp[EXP_W-1:0] : 11'b0, rfrac};

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            exp       <= '0;
            mant      <= '0;
            cnt       <= '0;
            c         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign <= in_sign;
                    exp  <= cap_exp;
                    mant <= cap_mant;
                    cnt  <= '0;
                    if (in_mant == '0) begin
                        c         <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= needs(cap_mant, cap_exp, 6'd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    mant  <= sh_mant;
                    exp   <= sh_exp;
                    cnt   <= sh_cnt;
                    state <= needs(sh_mant, sh_exp, sh_cnt) ? SHIFT : ROUND;
                end
                ROUND: begin
                    c         <= c_next;
                    overflow  <= ovf;
                    inexact   <= rinx | ovf;
                    underflow <= rinx & ~mant[55];
                    state     <= DONE;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_sub_normround.sv
// tb_fpu_sub_normround: randomized bench against a behavioural normalize/round model.
module tb_fpu_sub_normround;
    logic        clk = 0, rst = 1, in_valid = 0, in_sign = 0, out_ready = 0;
    logic [10:0] in_exp = 0;
    logic [56:0] in_mant = 0;
    logic        in_ready, out_valid, overflow, underflow, inexact;
    logic [63:0] c;

    fpu_sub_normround dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] c;
        logic ov, un, ix;
        int due;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0, rdy_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
        checks++;
        if (a !== b) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, b);
        end
    endtask

    function automatic void model(input logic sg, input logic [10:0] e, input logic [56:0] m,
                                  output logic [63:0] rc, output logic ov, output logic un,
                                  output logic ix, output int lat);
        logic [56:0] mm;
        int ex, k, rem;
        longint unsigned val;
        logic tiny;
        rc = 0; ov = 0; un = 0; ix = 0; lat = 1;
        if (m == 0) return;
        ex = (e == 0) ? 1 : int'(e);
        mm = m;
        if (mm[56]) begin
            mm = (mm >> 1) | {56'b0, m[0]};
            ex++;
        end
        k = 0;
        while (!mm[55] && ex > 1 && k < 54) begin
            mm = mm << 1;
            ex--;
            k++;
        end
        lat  = k + 2;
        val  = mm[55:3];
        rem  = int'(mm[2:0]);
        tiny = !mm[55];
        ix   = rem != 0;
        if (rem > 4 || (rem == 4 && val[0])) val++;
        if (val >= (64'd1 << 53)) begin
            val = val >> 1;
            ex++;
        end
        un = ix & tiny;
        if (ex >= 2047) begin
            rc = {sg, 11'h7FF, 52'b0};
            ov = 1;
            ix = 1;
        end else begin
            rc = {sg, (val >> 52) != 0 ? 11'(ex) : 11'd0, val[51:0]};
        end
    endfunction

    task automatic send(input logic sg, input logic [10:0] e, input logic [56:0] m);
        exp_t x;
        int lat, n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'b0, in_ready}, 64'd1);
            return;
        end
        in_sign = sg; in_exp = e; in_mant = m; in_valid = 1;
        model(sg, e, m, x.c, x.ov, x.un, x.ix, lat);
        x.due = cyc + lat;
        q.push_back(x);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 9) < 7);
    end

    exp_t cx;
    logic pv = 0;
    initial forever begin
        @(negedge clk);
        if (rst) pv = 0;
        else if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", {63'b0, out_valid}, 64'd0);
            else begin
                cx = q[0];
                chk("c", c, cx.c);
                chk("flags", {61'b0, overflow, underflow, inexact}, {61'b0, cx.ov, cx.un, cx.ix});
                chk("in_ready_busy", {63'b0, in_ready}, 64'd0);
                if (!pv) chk("latency", 64'(cyc), 64'(cx.due));
                if (out_ready) void'(q.pop_front());
            end
            pv = !out_ready;
        end else pv = 0;
    end

    logic [63:0] mc;
    logic mo, mu, mi;
    int ml, n;
    logic [63:0] held;
    logic [10:0] re;
    logic [63:0] raw;
    logic [56:0] rm;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_c", c, 64'd0);
        chk("rst_flags", {61'b0, overflow, underflow, inexact}, 64'd0);
        rst = 0;
        @(negedge clk);
        chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

        model(0, 1023, 57'd1 << 55, mc, mo, mu, mi, ml);
        chk("m_one", mc, 64'h3FF0000000000000); chk("m_one_lat", 64'(ml), 64'd2);
        model(0, 1023, 57'd1 << 52, mc, mo, mu, mi, ml);
        chk("m_eighth", mc, 64'h3FC0000000000000); chk("m_eighth_lat", 64'(ml), 64'd5);
        model(1, 1023, 57'd0, mc, mo, mu, mi, ml);
        chk("m_zero", mc, 64'd0); chk("m_zero_lat", 64'(ml), 64'd1);
        model(0, 1023, 57'h0FFFFFFFFFFFFFC, mc, mo, mu, mi, ml);
        chk("m_tie_odd", {mc, 3'b0, mi} , {64'h4000000000000000, 3'b0, 1'b1});
        model(0, 1023, 57'h0FFFFFFFFFFFFF4, mc, mo, mu, mi, ml);
        chk("m_tie_even", {mc, 3'b0, mi}, {64'h3FFFFFFFFFFFFFFE, 3'b0, 1'b1});
        model(0, 2046, 57'd1 << 56, mc, mo, mu, mi, ml);
        chk("m_ovf", {mc, 2'b0, mo, mi}, {64'h7FF0000000000000, 2'b0, 1'b1, 1'b1});
        model(0, 1, 57'h07FFFFFFFFFFFFC, mc, mo, mu, mi, ml);
        chk("m_sub_up", {mc, 2'b0, mu, mi}, {64'h0010000000000000, 2'b0, 1'b1, 1'b1});

        send(0, 1023, 57'd1 << 55);
        send(0, 1023, 57'd1 << 52);
        send(1, 1023, 57'd0);
        send(0, 1023, 57'h0FFFFFFFFFFFFFC);
        send(0, 1023, 57'h0FFFFFFFFFFFFF4);
        send(0, 2046, 57'd1 << 56);
        send(1, 1, 57'h07FFFFFFFFFFFFC);
        send(0, 0, 57'd1 << 54);
        send(0, 1023, 57'd1);

        n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        rdy_mode = 2;
        send(1, 1023, 57'd3 << 54);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid", {63'b0, out_valid}, 64'd1);
        held = c;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_c", c, held);
            chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        end
        rdy_mode = 1;

        send(0, 1023, 57'd1 << 30);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'b0, in_ready}, 64'd0);
        chk("abort_c", c, 64'd0);
        q.delete();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("abort_in_ready_after", {63'b0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: re = 0;
                1: re = 1;
                2: re = 11'($urandom_range(2, 60));
                3: re = 11'($urandom_range(2040, 2047));
                default: re = 11'($urandom);
            endcase
            raw = {$urandom, $urandom};
            rm = 57'(raw >> $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) rm[2:0] = 3'b100;
            send(1'($urandom), re, rm);
        end

        n = 0;
        while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
